// File: rtl/ball_pong.sv
// Pong ball engine: moves the ball once per animation step, bounces it off the walls and
// paddles, keeps both scores and drives the ball edges in the renderer's 12-bit format.
module ball_pong #(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned IX          = 320,
  parameter int unsigned IY          = 240,
  parameter int unsigned SPEED_X     = 2,
  parameter int unsigned SPEED_Y     = 2,
  parameter int unsigned D_WIDTH     = 639,
  parameter int unsigned D_HEIGHT    = 470,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_ani_stb,
  input  logic        in_animate,
  input  logic        in_serve,
  input  logic [11:0] in_l_x1,
  input  logic [11:0] in_l_x2,
  input  logic [11:0] in_l_y1,
  input  logic [11:0] in_l_y2,
  input  logic [11:0] in_r_x1,
  input  logic [11:0] in_r_x2,
  input  logic [11:0] in_r_y1,
  input  logic [11:0] in_r_y2,
  output logic [11:0] out_x1,
  output logic [11:0] out_x2,
  output logic [11:0] out_y1,
  output logic [11:0] out_y2,
  output logic [3:0]  out_score_l,
  output logic [3:0]  out_score_r,
  output logic        out_point_l,
  output logic        out_point_r,
  output logic [1:0]  out_state
);

  localparam logic [11:0] Size     = 12'(SIZE);
  localparam logic [11:0] InitX    = 12'(IX);
  localparam logic [11:0] InitY    = 12'(IY);
  localparam logic [11:0] SpeedX   = 12'(SPEED_X);
  localparam logic [11:0] SpeedY   = 12'(SPEED_Y);
  localparam logic [11:0] BottomY  = 12'(D_HEIGHT - SIZE - SPEED_Y);
  localparam logic [11:0] TopY     = 12'(SIZE + SPEED_Y);
  localparam logic [11:0] RightX   = 12'(D_WIDTH - SIZE - SPEED_X);
  localparam logic [11:0] LeftX    = 12'(SIZE + SPEED_X);
  localparam logic [7:0]  HoldLast = 8'(HOLD_FRAMES);
  localparam logic [3:0]  WinScore = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StWait = 2'd0, StPlay = 2'd1, StScored = 2'd2, StOver = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d;           // 1 = right
  logic        dy_q, dy_d;           // 1 = down
  logic        serve_dir_q, serve_dir_d;
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic        point_l_q, point_l_d, point_r_q, point_r_d;
  logic [7:0]  hold_q, hold_d;

  logic step;
  logic overlap_l, overlap_r, hit_l, hit_r;
  logic [3:0] score_inc;

  // Bar x1 edges on the left and x2 edges on the right are outside the hit logic.
  logic unused_edges;
  assign unused_edges = ^{in_l_x1, in_r_x2};

  assign step      = in_ani_stb & in_animate;
  assign overlap_l = (y_q + Size >= in_l_y1) && (y_q - Size <= in_l_y2);
  assign overlap_r = (y_q + Size >= in_r_y1) && (y_q - Size <= in_r_y2);
  assign hit_l     = !dx_q && (x_q - Size >= in_l_x2) && (x_q - Size - SpeedX <= in_l_x2)
                     && overlap_l;
  assign hit_r     = dx_q && (x_q + Size <= in_r_x1) && (x_q + Size + SpeedX >= in_r_x1)
                     && overlap_r;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_dir_d = serve_dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    hold_d      = hold_q;
    score_inc   = 4'd0;
    if (step) begin
      unique case (state_q)
        StWait: begin
          if (in_serve) begin
            state_d = StPlay;
            dx_d    = serve_dir_q;
            dy_d    = 1'b1;
          end
        end
        StPlay: begin
          if (dy_q && (y_q >= BottomY)) begin
            dy_d = 1'b0;
            y_d  = y_q - SpeedY;
          end else if (!dy_q && (y_q <= TopY)) begin
            dy_d = 1'b1;
            y_d  = y_q + SpeedY;
          end else begin
            y_d = dy_q ? y_q + SpeedY : y_q - SpeedY;
          end

          if (hit_l) begin
            dx_d = 1'b1;
            x_d  = x_q + SpeedX;
          end else if (hit_r) begin
            dx_d = 1'b0;
            x_d  = x_q - SpeedX;
          end else if (!dx_q && (x_q <= LeftX)) begin
            // Right player scores; the ball freezes where it is.
            score_inc   = score_r_q + 4'd1;
            score_r_d   = score_inc;
            point_r_d   = 1'b1;
            serve_dir_d = 1'b0;
            x_d         = x_q;
            y_d         = y_q;
            dy_d        = dy_q;
            hold_d      = 8'd0;
            state_d     = (score_inc == WinScore) ? StOver : StScored;
          end else if (dx_q && (x_q >= RightX)) begin
            score_inc   = score_l_q + 4'd1;
            score_l_d   = score_inc;
            point_l_d   = 1'b1;
            serve_dir_d = 1'b1;
            x_d         = x_q;
            y_d         = y_q;
            dy_d        = dy_q;
            hold_d      = 8'd0;
            state_d     = (score_inc == WinScore) ? StOver : StScored;
          end else begin
            x_d = dx_q ? x_q + SpeedX : x_q - SpeedX;
          end
        end
        StScored: begin
          hold_d = hold_q + 8'd1;
          if (hold_d == HoldLast) begin
            x_d     = InitX;
            y_d     = InitY;
            state_d = StWait;
          end
        end
        StOver: ;
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= StWait;
      x_q         <= InitX;
      y_q         <= InitY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_dir_q <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_dir_q <= serve_dir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      hold_q      <= hold_d;
    end
  end

  assign out_x1      = x_q - Size;
  assign out_x2      = x_q + Size;
  assign out_y1      = y_q - Size;
  assign out_y2      = y_q + Size;
  assign out_score_l = score_l_q;
  assign out_score_r = score_r_q;
  assign out_point_l = point_l_q;
  assign out_point_r = point_r_q;
  assign out_state   = state_q;

endmodule

// File: tb/tb_ball_pong.sv
// Directed bench for ball_pong: a table of step batches with hand-traced ball positions,
// plus hand-written sequences for game over and asynchronous reset.
module tb_ball_pong;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ani_stb, animate, serve;
  logic [11:0] l_x1, l_x2, l_y1, l_y2, r_x1, r_x2, r_y1, r_y2;
  logic [11:0] x1, x2, y1, y2;
  logic [3:0]  score_l, score_r;
  logic        point_l, point_r;
  logic [1:0]  state;

  always #5 clk = ~clk;

  ball_pong dut (
    .in_clock    (clk),
    .in_reset    (rst_n),
    .in_ani_stb  (ani_stb),
    .in_animate  (animate),
    .in_serve    (serve),
    .in_l_x1     (l_x1),
    .in_l_x2     (l_x2),
    .in_l_y1     (l_y1),
    .in_l_y2     (l_y2),
    .in_r_x1     (r_x1),
    .in_r_x2     (r_x2),
    .in_r_y1     (r_y1),
    .in_r_y2     (r_y2),
    .out_x1      (x1),
    .out_x2      (x2),
    .out_y1      (y1),
    .out_y2      (y2),
    .out_score_l (score_l),
    .out_score_r (score_r),
    .out_point_l (point_l),
    .out_point_r (point_r),
    .out_state   (state)
  );

  // lsel: 0 far away, 1 x2=20 y 150..330, 2 x2=20 full height; rsel: 0 far, 1 x1=600 full.
  typedef struct {
    string name;
    int    n;
    bit    srv;
    bit    anim;
    int    lsel;
    int    rsel;
    int    ex, ey, est, esl, esr, epl, epr;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void add(string name, int n, bit srv, bit anim, int lsel, int rsel,
                              int ex, int ey, int est, int esl, int esr, int epl, int epr);
    vec_t v;
    v.name = name; v.n = n; v.srv = srv; v.anim = anim; v.lsel = lsel; v.rsel = rsel;
    v.ex = ex; v.ey = ey; v.est = est; v.esl = esl; v.esr = esr; v.epl = epl; v.epr = epr;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(string nm, int ex, int ey, int est, int esl, int esr, int epl,
                           int epr);
    chk({nm, ".x1"}, 32'(x1), 32'(ex - 8));
    chk({nm, ".x2"}, 32'(x2), 32'(ex + 8));
    chk({nm, ".y1"}, 32'(y1), 32'(ey - 8));
    chk({nm, ".y2"}, 32'(y2), 32'(ey + 8));
    chk({nm, ".state"}, 32'(state), 32'(est));
    chk({nm, ".score_l"}, 32'(score_l), 32'(esl));
    chk({nm, ".score_r"}, 32'(score_r), 32'(esr));
    chk({nm, ".point_l"}, 32'(point_l), 32'(epl));
    chk({nm, ".point_r"}, 32'(point_r), 32'(epr));
  endtask

  task automatic set_bars(int lsel, int rsel);
    l_x1 = 12'd10;
    r_x2 = 12'd4010;
    unique case (lsel)
      1:       begin l_x2 = 12'd20; l_y1 = 12'd150; l_y2 = 12'd330;  end
      2:       begin l_x2 = 12'd20; l_y1 = 12'd0;   l_y2 = 12'd479;  end
      default: begin l_x2 = 12'd0;  l_y1 = 12'd4000; l_y2 = 12'd4000; end
    endcase
    if (rsel == 1) begin
      r_x1 = 12'd600; r_y1 = 12'd0; r_y2 = 12'd479;
    end else begin
      r_x1 = 12'd4000; r_y1 = 12'd4000; r_y2 = 12'd4000;
    end
  endtask

  // One strobe cycle; returns on the falling edge right after the strobe edge.
  task automatic do_step(bit srv, bit anim);
    @(negedge clk);
    ani_stb = 1'b1;
    animate = anim;
    serve   = srv;
    @(negedge clk);
    ani_stb = 1'b0;
    serve   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b0; serve = 1'b0;
    set_bars(0, 0);

    //  name          n  srv an  l  r   x    y   st sl sr pl pr
    add("idle",       1, 0, 1, 0, 0, 320, 240, 0, 0, 0, 0, 0);
    add("serve",      1, 1, 1, 0, 0, 320, 240, 1, 0, 0, 0, 0);
    add("first_mv",   1, 0, 1, 0, 0, 322, 242, 1, 0, 0, 0, 0);
    add("no_anim",    5, 0, 0, 0, 0, 322, 242, 1, 0, 0, 0, 0);
    add("to_bottom",109, 0, 1, 0, 0, 540, 460, 1, 0, 0, 0, 0);
    add("bot_bounce", 1, 0, 1, 0, 0, 542, 458, 1, 0, 0, 0, 0);
    add("to_right",  44, 0, 1, 0, 0, 630, 370, 1, 0, 0, 0, 0);
    add("pt_left",    1, 0, 1, 0, 0, 630, 370, 2, 1, 0, 1, 0);
    add("hold_nostep",1, 0, 0, 0, 0, 630, 370, 2, 1, 0, 0, 0);
    add("hold_58",   58, 0, 1, 0, 0, 630, 370, 2, 1, 0, 0, 0);
    add("hold_59",    1, 0, 1, 0, 0, 630, 370, 2, 1, 0, 0, 0);
    add("hold_60",    1, 0, 1, 0, 0, 320, 240, 0, 1, 0, 0, 0);
    add("serve2",     1, 1, 1, 1, 1, 320, 240, 1, 1, 0, 0, 0);
    add("to_rpad",  135, 0, 1, 1, 1, 590, 410, 1, 1, 0, 0, 0);
    add("rpad_hit",   1, 0, 1, 1, 1, 588, 408, 1, 1, 0, 0, 0);
    add("to_top",   199, 0, 1, 1, 0, 190,  10, 1, 1, 0, 0, 0);
    add("top_bounce", 1, 0, 1, 1, 0, 188,  12, 1, 1, 0, 0, 0);
    add("to_lpad",   79, 0, 1, 1, 0,  30, 170, 1, 1, 0, 0, 0);
    add("lpad_hit",   1, 0, 1, 1, 0,  32, 172, 1, 1, 0, 0, 0);
    add("to_rpad2", 279, 0, 1, 1, 1, 590, 190, 1, 1, 0, 0, 0);
    add("rpad_hit2",  1, 0, 1, 1, 1, 588, 188, 1, 1, 0, 0, 0);
    add("lpad_miss",289, 0, 1, 1, 0,  10, 410, 1, 1, 0, 0, 0);
    add("pt_right",   1, 0, 1, 1, 0,  10, 410, 2, 1, 1, 0, 1);
    add("hold2",     60, 0, 1, 1, 0, 320, 240, 0, 1, 1, 0, 0);
    add("serve3",     1, 1, 1, 2, 0, 320, 240, 1, 1, 1, 0, 0);
    add("serve_left", 1, 0, 1, 2, 0, 318, 242, 1, 1, 1, 0, 0);
    add("to_lpad3", 144, 0, 1, 2, 0,  30, 390, 1, 1, 1, 0, 0);
    add("lpad_hit3",  1, 0, 1, 2, 0,  32, 388, 1, 1, 1, 0, 0);
    add("to_right3",299, 0, 1, 2, 0, 630, 230, 1, 1, 1, 0, 0);
    add("pt_left2",   1, 0, 1, 2, 0, 630, 230, 2, 2, 1, 1, 0);
    add("hold3",     60, 0, 1, 2, 0, 320, 240, 0, 2, 1, 0, 0);

    repeat (2) @(negedge clk);
    check_out("reset", 320, 240, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_bars(tbl[i].lsel, tbl[i].rsel);
      for (int s = 0; s < tbl[i].n; s++) do_step(tbl[i].srv, tbl[i].anim);
      check_out(tbl[i].name, tbl[i].ex, tbl[i].ey, tbl[i].est, tbl[i].esl, tbl[i].esr,
                tbl[i].epl, tbl[i].epr);
    end

    // Left player wins from 2 points: every serve goes right and runs off the far edge.
    set_bars(0, 0);
    for (int r = 0; r < 5; r++) begin
      do_step(1'b1, 1'b1);
      check_out("round_serve", 320, 240, 1, 2 + r, 1, 0, 0);
      repeat (155) do_step(1'b0, 1'b1);
      check_out("round_edge", 630, 370, 1, 2 + r, 1, 0, 0);
      do_step(1'b0, 1'b1);
      check_out("round_point", 630, 370, (r == 4) ? 3 : 2, 3 + r, 1, 1, 0);
      if (r < 4) begin
        repeat (60) do_step(1'b0, 1'b1);
        check_out("round_hold", 320, 240, 0, 3 + r, 1, 0, 0);
      end
    end
    repeat (3) do_step(1'b1, 1'b1);
    check_out("over_frozen", 630, 370, 3, 7, 1, 0, 0);

    // Asynchronous reset out of OVER, away from any clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("reset_over", 320, 240, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of play.
    do_step(1'b1, 1'b1);
    repeat (3) do_step(1'b0, 1'b1);
    check_out("play_again", 326, 246, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("reset_play", 320, 240, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_pong.md
Name: ball_pong

Overview:
Ball engine for the pong game. It sits directly downstream of the two bar instances and consumes their edge outputs (x1/x2/y1/y2) to detect paddle hits. It moves the ball once per animation strobe, bounces it off the top/bottom walls and the paddles, and keeps both players' scores. It drives ball edges in the same 12-bit edge format the renderer already uses for bars.

Parameters:
SIZE, 8, half ball side in pixels
IX, 320, initial/serve centre x
IY, 240, initial/serve centre y
SPEED_X, 2, horizontal pixels per strobe
SPEED_Y, 2, vertical pixels per strobe
D_WIDTH, 639, display width
D_HEIGHT, 470, display height
HOLD_FRAMES, 60, strobes the ball stays frozen after a point (1..255)
WIN_SCORE, 7, score that ends the game (1..15)

Ports:
in_clock  in  1  base clock
in_reset  in  1  asynchronous, active-low reset
in_ani_stb  in  1  animation strobe, one in_clock cycle per frame
in_animate  in  1  strobes are honoured only while high
in_serve  in  1  serve request, level, sampled on a strobe
in_l_x1, in_l_x2, in_l_y1, in_l_y2  in  12 each  left bar edges
in_r_x1, in_r_x2, in_r_y1, in_r_y2  in  12 each  right bar edges
out_x1, out_x2, out_y1, out_y2  out  12 each  ball edges: x±SIZE, y±SIZE (combinational from centre)
out_score_l, out_score_r  out  4 each  player scores
out_point_l, out_point_r  out  1 each  one-in_clock pulse when that player scores
out_state  out  2  0=WAIT 1=PLAY 2=SCORED 3=OVER

Behaviour:
- One clock: in_clock. Reset is asynchronous and active-low (in_reset=0). On reset: x=IX, y=IY, dx=right, dy=down, scores=0, hold counter=0, pulses=0, state=WAIT, serve direction=right.
- Step: a step is a cycle with in_ani_stb=1 and in_animate=1. All state changes except reset and pulse clearing happen only on steps.
- WAIT: ball held at (IX,IY). If in_serve=1 on a step: state becomes PLAY, dx becomes the serve direction, dy becomes down. No motion on that step.
- PLAY, vertical motion, evaluated on current y:
  - If dy=down and y >= D_HEIGHT-SIZE-SPEED_Y: dy becomes up and y becomes y-SPEED_Y.
  - Else if dy=up and y <= SIZE+SPEED_Y: dy becomes down and y becomes y+SPEED_Y.
  - Otherwise y moves SPEED_Y in direction dy.
- PLAY, horizontal motion, evaluated on current x. Vertical overlap with a bar means y+SIZE >= by1 and y-SIZE <= by2, inclusive, using current y.
  - Left paddle hit: dx=left, x-SIZE >= in_l_x2, x-SIZE-SPEED_X <= in_l_x2, and overlap with the left bar. Result: dx becomes right and x becomes x+SPEED_X.
  - Right paddle hit: the mirror case using in_r_x1 (x+SIZE <= in_r_x1 and x+SIZE+SPEED_X >= in_r_x1). Result: dx becomes left and x becomes x-SPEED_X.
  - Else if dx=left and x <= SIZE+SPEED_X: the right player scores.
  - Else if dx=right and x >= D_WIDTH-SIZE-SPEED_X: the left player scores.
  - Otherwise x moves SPEED_X in direction dx.
  - Priority: paddle hit over score. The vertical and horizontal updates are independent and both apply on the same step.
- Score event:
  - The scorer's count increments.
  - The matching out_point_* is high for exactly the next in_clock cycle.
  - Ball position is frozen at its current value.
  - Serve direction is set toward the player who conceded.
  - Hold counter loads 0.
  - State becomes OVER if the new count equals WIN_SCORE, else SCORED.
- SCORED: the hold counter increments on each step. When it reaches HOLD_FRAMES: x=IX, y=IY, state=WAIT. Non-step cycles do not advance the counter.
- OVER: ball frozen, in_serve ignored. Only reset exits this state.
- Arithmetic: all values are 12-bit unsigned. Parameters must guarantee no underflow or overflow (SIZE+SPEED < IX, D_WIDTH+SIZE < 4096).
- Bar inputs are sampled every step and used as-is. A bar moving on the same step uses its pre-move edges, since bar registers update on the same edge.
- Reset asserted in any state takes effect immediately, including mid-hold and mid-pulse.

Test Plan:
1. Reset in PLAY at x=100: drive in_reset=0 -> out_x1=312, out_x2=328, out_y1=232, out_y2=248, scores 0, out_state=0, with no clock edge needed.
2. Serve: WAIT, in_serve=1 on a step -> out_state=1. The next step gives centre (322,242). in_animate=0 with strobes leaves the ball unmoved.
3. Bottom bounce: dy=down, y=460 -> next step y=458, dy=up. At y=10 moving up -> y=12, dy=down.
4. Left paddle hit: in_l_x2=20, in_l_y1=150, in_l_y2=330, ball dx=left at x=30, y=240 -> x=32, dx=right. Repeat with in_l_y1=300, in_l_y2=480 -> ball passes; at x=10 out_point_r pulses 1 cycle, out_score_r=1, out_state=2.
5. Hold: after a point, 59 steps leave the ball frozen and state=2. The 60th step gives (320,240) and state=0. The next serve moves the ball left.
6. Game over: out_score_l=6, left player scores -> out_score_l=7, out_state=3. in_serve and strobes thereafter leave all outputs unchanged until reset.
